// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response and word-memory signals of the load/store unit.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic                  is_store;
  logic [2:0]            op;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           store_data;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [31:0]           load_data;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_read;
  logic                  mem_write;
  logic [31:0]           mem_rdata;

  // Pipeline control plus data memory, seen from outside the unit
  modport master (
    output req, is_store, op, addr, store_data, mem_rdata,
    input  busy, done, err, load_data, mem_addr, mem_wdata, mem_read, mem_write
  );

  // The load/store unit itself
  modport slave (
    input  req, is_store, op, addr, store_data, mem_rdata,
    output busy, done, err, load_data, mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word loads with sign/zero extension and
// read-modify-write sub-word stores against a big-endian word memory.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  load_store_unit_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]            state;
  logic                  st_r;
  logic [2:0]            op_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [15:0]           sdata_r;
  logic [31:0]           wdata_r;
  logic                  err_r;
  logic [31:0]           load_r;

  logic                  dec_illegal;
  logic                  dec_misal;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [31:0]           load_ext;
  logic [31:0]           merged;

  // Classify the incoming request as illegal or misaligned
  always_comb begin
    dec_illegal = (bus.op[1:0] == 2'b10) || (bus.op == 3'b111) ||
                  (bus.is_store && bus.op[2]);
    dec_misal   = ((bus.op[1:0] == 2'b01) && bus.addr[0]) ||
                  ((bus.op[1:0] == 2'b11) && (bus.addr[1:0] != 2'b00));
  end

  // Lane extraction/extension for loads and lane merge for sub-word stores
  always_comb begin
    byte_sel = '0;
    case (addr_r[1:0])
      2'd0: byte_sel = bus.mem_rdata[31:24];
      2'd1: byte_sel = bus.mem_rdata[23:16];
      2'd2: byte_sel = bus.mem_rdata[15:8];
      default: byte_sel = bus.mem_rdata[7:0];
    endcase
    half_sel = addr_r[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];

    case (op_r[1:0])
      2'b00:   load_ext = {{24{~op_r[2] & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{~op_r[2] & half_sel[15]}}, half_sel};
      default: load_ext = bus.mem_rdata;
    endcase

    merged = bus.mem_rdata;
    if (op_r[1:0] == 2'b00) begin
      case (addr_r[1:0])
        2'd0: merged[31:24] = sdata_r[7:0];
        2'd1: merged[23:16] = sdata_r[7:0];
        2'd2: merged[15:8]  = sdata_r[7:0];
        default: merged[7:0] = sdata_r[7:0];
      endcase
    end else if (addr_r[1]) begin
      merged[15:0] = sdata_r;
    end else begin
      merged[31:16] = sdata_r;
    end
  end

  // Request sequencing: IDLE -> (RD) -> (WR) -> DONE -> IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      st_r    <= 1'b0;
      op_r    <= '0;
      addr_r  <= '0;
      sdata_r <= '0;
      wdata_r <= '0;
      err_r   <= 1'b0;
      load_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            st_r    <= bus.is_store;
            op_r    <= bus.op;
            addr_r  <= bus.addr;
            sdata_r <= bus.store_data[15:0];
            if (dec_illegal || dec_misal) begin
              err_r <= 1'b1;
              state <= DONE;
            end else begin
              err_r <= 1'b0;
              if (!bus.is_store) begin
                state <= RD;
              end else if (bus.op[1:0] == 2'b11) begin
                wdata_r <= bus.store_data;
                state   <= WR;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD: begin
          if (st_r) begin
            wdata_r <= merged;
            state   <= WR;
          end else begin
            load_r <= load_ext;
            state  <= DONE;
          end
        end
        WR:      state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state so reset clears them at once
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.err       = (state == DONE) && err_r;
  assign bus.load_data = load_r;
  assign bus.mem_read  = (state == RD);
  assign bus.mem_write = (state == WR);
  assign bus.mem_addr  = ((state == RD) || (state == WR)) ?
                         {addr_r[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign bus.mem_wdata = (state == WR) ? wdata_r : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a small behavioural word memory.
module tb_load_store_unit;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [31:0] last_wdata;
  logic [31:0] last_waddr;
  logic [31:0] mem [0:63];

  load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request and follow it to done, counting memory strobes
  task automatic run_op(input string tag, input logic st, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] sd,
                        input int exp_lat, input logic exp_err,
                        input int exp_rd, input int exp_wr);
    int   cyc;
    int   nrd;
    int   nwr;
    logic got_done;
    logic e;
    @(posedge clk); #1;
    bus.req = 1'b1; bus.is_store = st; bus.op = o; bus.addr = a; bus.store_data = sd;
    @(posedge clk); #1;
    bus.req = 1'b0;
    cyc = 1; nrd = 0; nwr = 0; got_done = 1'b0; e = 1'b0;
    while (!got_done && cyc <= 8) begin
      @(negedge clk);
      if (bus.mem_read) nrd++;
      if (bus.mem_write) begin
        nwr++;
        last_wdata = bus.mem_wdata;
        last_waddr = bus.mem_addr;
      end
      if (bus.done) begin
        got_done = 1'b1;
        e = bus.err;
      end else begin
        @(posedge clk);
        cyc++;
      end
    end
    check({tag, "_lat"}, got_done ? 32'(cyc) : 32'd99, 32'(exp_lat));
    check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    check({tag, "_nrd"}, 32'(nrd), 32'(exp_rd));
    check({tag, "_nwr"}, 32'(nwr), 32'(exp_wr));
  endtask

  initial begin
    logic [4:0] done_pat;
    logic [4:0] busy_pat;
    int         nrd;
    n_tests = 0; n_fail = 0;
    last_wdata = '0; last_waddr = '0;
    rst = 1'b1;
    bus.req = 1'b0; bus.is_store = 1'b0; bus.op = '0; bus.addr = '0; bus.store_data = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  {31'd0, bus.busy}, 32'd0);
    check("rst_done",  {31'd0, bus.done}, 32'd0);
    check("rst_err",   {31'd0, bus.err}, 32'd0);
    check("rst_ld",    bus.load_data, 32'd0);
    check("rst_mrd",   {31'd0, bus.mem_read}, 32'd0);
    check("rst_mwr",   {31'd0, bus.mem_write}, 32'd0);
    check("rst_maddr", bus.mem_addr, 32'd0);
    check("rst_mwd",   bus.mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Preload word 0x10 through a word store
    run_op("sw10", 1'b1, 3'b011, 32'h10, 32'h8899AABB, 2, 1'b0, 0, 1);
    check("sw10_wd", last_wdata, 32'h8899AABB);
    check("sw10_wa", last_waddr, 32'h10);

    run_op("lb11", 1'b0, 3'b000, 32'h11, 32'h0, 2, 1'b0, 1, 0);
    check("lb11_ld", bus.load_data, 32'hFFFFFF99);
    run_op("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 2, 1'b0, 1, 0);
    check("lbu13_ld", bus.load_data, 32'h000000BB);
    run_op("lh10", 1'b0, 3'b001, 32'h10, 32'h0, 2, 1'b0, 1, 0);
    check("lh10_ld", bus.load_data, 32'hFFFF8899);
    run_op("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 2, 1'b0, 1, 0);
    check("lhu12_ld", bus.load_data, 32'h0000AABB);
    run_op("lw10", 1'b0, 3'b011, 32'h10, 32'h0, 2, 1'b0, 1, 0);
    check("lw10_ld", bus.load_data, 32'h8899AABB);

    run_op("sb12", 1'b1, 3'b000, 32'h12, 32'h12345655, 3, 1'b0, 1, 1);
    check("sb12_wd", last_wdata, 32'h889955BB);
    check("sb12_wa", last_waddr, 32'h10);
    run_op("lw10b", 1'b0, 3'b011, 32'h10, 32'h0, 2, 1'b0, 1, 0);
    check("lw10b_ld", bus.load_data, 32'h889955BB);

    // Error paths: no memory access, load_data untouched
    run_op("sw15", 1'b1, 3'b011, 32'h15, 32'hCAFEF00D, 1, 1'b1, 0, 0);
    run_op("lh13", 1'b0, 3'b001, 32'h13, 32'h0, 1, 1'b1, 0, 0);
    run_op("sbu", 1'b1, 3'b100, 32'h10, 32'h000000EE, 1, 1'b1, 0, 0);
    run_op("op010", 1'b0, 3'b010, 32'h10, 32'h0, 1, 1'b1, 0, 0);
    check("err_ld", bus.load_data, 32'h889955BB);
    check("err_mem", mem[4], 32'h889955BB);

    // Half store into low half, then read back the whole word
    run_op("sw14", 1'b1, 3'b011, 32'h14, 32'hDEADBEEF, 2, 1'b0, 0, 1);
    run_op("sh16", 1'b1, 3'b001, 32'h16, 32'hFFFF1234, 3, 1'b0, 1, 1);
    check("sh16_wd", last_wdata, 32'hDEAD1234);
    run_op("lw14", 1'b0, 3'b011, 32'h14, 32'h0, 2, 1'b0, 1, 0);
    check("lw14_ld", bus.load_data, 32'hDEAD1234);

    // Reset while a half store is in its read phase
    @(posedge clk); #1;
    bus.req = 1'b1; bus.is_store = 1'b1; bus.op = 3'b001; bus.addr = 32'h10; bus.store_data = 32'h00007777;
    @(posedge clk); #1;
    bus.req = 1'b0;
    check("shrst_mrd1", {31'd0, bus.mem_read}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("shrst_mrd0",  {31'd0, bus.mem_read}, 32'd0);
    check("shrst_mwr0",  {31'd0, bus.mem_write}, 32'd0);
    check("shrst_busy",  {31'd0, bus.busy}, 32'd0);
    check("shrst_maddr", bus.mem_addr, 32'd0);
    check("shrst_ld",    bus.load_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("shrst_mem", mem[4], 32'h889955BB);
    run_op("lw_after", 1'b0, 3'b011, 32'h10, 32'h0, 2, 1'b0, 1, 0);
    check("lw_after_ld", bus.load_data, 32'h889955BB);

    // req held high: one access per accepted request, back-to-back after done
    @(posedge clk); #1;
    bus.req = 1'b1; bus.is_store = 1'b0; bus.op = 3'b011; bus.addr = 32'h14; bus.store_data = '0;
    done_pat = '0; busy_pat = '0; nrd = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      done_pat[i] = bus.done;
      busy_pat[i] = bus.busy;
      if (bus.mem_read) nrd++;
    end
    bus.req = 1'b0;
    check("hold_done", {27'd0, done_pat}, 32'b10010);
    check("hold_busy", {27'd0, busy_pat}, 32'b11011);
    check("hold_nrd",  32'(nrd), 32'd2);
    check("hold_ld",   bus.load_data, 32'hDEAD1234);
    @(posedge clk);
    @(negedge clk);
    check("hold_idle", {31'd0, bus.busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
